// File: rtl/chip_test_sequencer.sv
// Functional test sequencer for a 14-pin DIP logic chip.
// Fetches ROM vectors, drives pins, settles, samples and scores.
module chip_test_sequencer #(
  parameter int NPINS         = 14,
  parameter int ADDR_W        = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int ERR_W         = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Run,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [NPINS-1:0]  vec_drive,
  input  logic [NPINS-1:0]  vec_oe,
  input  logic [NPINS-1:0]  vec_expect,
  input  logic [NPINS-1:0]  vec_mask,
  input  logic              vec_last,
  input  logic [NPINS-1:0]  pin_in,
  output logic [NPINS-1:0]  pin_out,
  output logic [NPINS-1:0]  pin_oe,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [NPINS-1:0]  fail_pins
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_APPLY,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t            state;
  logic              run_s1;
  logic              run_s2;
  logic              run_d;
  logic [NPINS-1:0]  pin_s1;
  logic [NPINS-1:0]  pin_s2;
  logic [NPINS-1:0]  exp_q;
  logic [NPINS-1:0]  eff_q;
  logic              last_q;
  logic              wrap;
  logic [CNT_W-1:0]  cnt;
  logic              start;
  logic [NPINS-1:0]  mism;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      run_s1 <= 1'b1;
      run_s2 <= 1'b1;
      run_d  <= 1'b1;
      pin_s1 <= '0;
      pin_s2 <= '0;
    end else begin
      run_s1 <= Run;
      run_s2 <= run_s1;
      run_d  <= run_s2;
      pin_s1 <= pin_in;
      pin_s2 <= pin_s1;
    end
  end

  assign start = run_d & ~run_s2;
  assign mism  = (pin_s2 ^ exp_q) & eff_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IDLE;
      vec_addr  <= '0;
      pin_out   <= '0;
      pin_oe    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      fail_pins <= '0;
      exp_q     <= '0;
      eff_q     <= '0;
      last_q    <= 1'b0;
      wrap      <= 1'b0;
      cnt       <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (state == S_DONE) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_count == '0) && !wrap;
          end
          if (start) begin
            vec_addr  <= base_addr;
            err_count <= '0;
            fail_addr <= '0;
            fail_pins <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            wrap      <= 1'b0;
            busy      <= 1'b1;
            state     <= S_FETCH;
          end
        end
        S_FETCH: state <= S_APPLY;
        S_APPLY: begin
          pin_out <= vec_drive;
          pin_oe  <= vec_oe;
          exp_q   <= vec_expect;
          eff_q   <= vec_mask & ~vec_oe;
          last_q  <= vec_last;
          cnt     <= CNT_W'(SETTLE_CYCLES - 1);
          state   <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt == '0) state <= S_SAMPLE;
          else cnt <= cnt - 1'b1;
        end
        S_SAMPLE: begin
          if (mism != '0) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            // err_count only leaves zero on the first mismatch of a run
            if (err_count == '0) begin
              fail_addr <= vec_addr;
              fail_pins <= mism;
            end
          end
          if (last_q) begin
            pin_oe <= '0;
            state  <= S_DONE;
          end else if (vec_addr == '1) begin
            wrap   <= 1'b1;
            pin_oe <= '0;
            state  <= S_DONE;
          end else begin
            vec_addr <= vec_addr + 1'b1;
            state    <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chip_test_sequencer.sv
// Scoreboard bench for chip_test_sequencer with a ROM and a 7400 model.
// Expected run results are queued; a monitor checks them on done.
module tb_chip_test_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Run = 1'b1;
  logic [7:0]  base_addr = '0;
  logic [7:0]  vec_addr;
  logic [13:0] vec_drive, vec_oe, vec_expect, vec_mask;
  logic        vec_last;
  logic [13:0] pin_in, pin_out, pin_oe, fail_pins;
  logic        busy, done, pass;
  logic [7:0]  err_count, fail_addr;

  logic [13:0] r_drive [256];
  logic [13:0] r_oe    [256];
  logic [13:0] r_exp   [256];
  logic [13:0] r_mask  [256];
  logic        r_last  [256];

  int mode = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        pass;
    logic [7:0]  err;
    logic [7:0]  fa;
    logic [13:0] fp;
    logic [7:0]  addr;
    int          bcnt;
  } exp_t;

  exp_t sbq[$];

  chip_test_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .base_addr(base_addr),
    .vec_addr(vec_addr), .vec_drive(vec_drive), .vec_oe(vec_oe),
    .vec_expect(vec_expect), .vec_mask(vec_mask), .vec_last(vec_last),
    .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe), .busy(busy),
    .done(done), .pass(pass), .err_count(err_count),
    .fail_addr(fail_addr), .fail_pins(fail_pins)
  );

  always #10 Clk = ~Clk;

  always @(posedge Clk) begin
    vec_drive  <= r_drive[vec_addr];
    vec_oe     <= r_oe[vec_addr];
    vec_expect <= r_exp[vec_addr];
    vec_mask   <= r_mask[vec_addr];
    vec_last   <= r_last[vec_addr];
  end

  // mode 0: good 7400, mode 1: pin 3 stuck low, mode 2: plain loopback
  always_comb begin
    logic [13:0] p;
    p = pin_out & pin_oe;
    pin_in = p;
    if (mode != 2) begin
      pin_in[2]  = ~(p[0] & p[1]) & (mode != 1);
      pin_in[5]  = ~(p[3] & p[4]);
      pin_in[7]  = ~(p[8] & p[9]);
      pin_in[10] = ~(p[11] & p[12]);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic busy_prev = 1'b0;
  logic done_prev = 1'b0;
  int   bcnt = 0;

  always @(negedge Clk) begin
    exp_t e;
    if (busy && !busy_prev) bcnt = 1;
    else if (busy) bcnt++;
    if (done && !done_prev) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'(sbq.size()), 32'd1);
      end else begin
        e = sbq.pop_front();
        chk("pass", 32'(pass), 32'(e.pass));
        chk("err_count", 32'(err_count), 32'(e.err));
        chk("fail_addr", 32'(fail_addr), 32'(e.fa));
        chk("fail_pins", 32'(fail_pins), 32'(e.fp));
        chk("vec_addr", 32'(vec_addr), 32'(e.addr));
        chk("busy_cycles", 32'(bcnt), 32'(e.bcnt));
      end
    end
    busy_prev = busy;
    done_prev = done;
  end

  task automatic set_vec(input int a, input logic [13:0] d, oe, e, m,
                         input logic l);
    r_drive[a] = d;
    r_oe[a]    = oe;
    r_exp[a]   = e;
    r_mask[a]  = m;
    r_last[a]  = l;
  endtask

  task automatic push(input logic p, input logic [7:0] er, fa,
                      input logic [13:0] fp, input logic [7:0] ad,
                      input int bc);
    exp_t e;
    e.pass = p; e.err = er; e.fa = fa; e.fp = fp; e.addr = ad; e.bcnt = bc;
    sbq.push_back(e);
  endtask

  task automatic pulse_run();
    @(posedge Clk); #1 Run = 1'b0;
    repeat (4) @(posedge Clk);
    #1 Run = 1'b1;
    repeat (4) @(posedge Clk);
  endtask

  task automatic wait_sb(input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge Clk);
      n++;
    end
    chk("run_timeout", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) set_vec(i, '0, '0, '0, '0, 1'b1);
    // 7400: oe covers A/B inputs plus GND and VCC; Y pins sampled
    set_vec(8'h10, 14'h3910, 14'h3B5B, 14'h00A4, 14'h3FFF, 1'b0);
    set_vec(8'h11, 14'h2A03, 14'h3B5B, 14'h04A0, 14'h3FFF, 1'b0);
    set_vec(8'h12, 14'h300B, 14'h3B5B, 14'h04A0, 14'h3FFF, 1'b0);
    set_vec(8'h13, 14'h231B, 14'h3B5B, 14'h0400, 14'h3FFF, 1'b1);

    repeat (3) @(negedge Clk);
    chk("rst_pin_oe", 32'(pin_oe), 32'd0);
    chk("rst_pin_out", 32'(pin_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_vec_addr", 32'(vec_addr), 32'd0);
    @(posedge Clk); #1 Reset = 1'b1;
    repeat (3) @(posedge Clk);

    // good chip, extra Run press while busy must be ignored
    base_addr = 8'h10;
    push(1'b1, 8'h00, 8'h00, 14'h0000, 8'h13, 4 * 19 + 1);
    pulse_run();
    repeat (20) @(posedge Clk);
    pulse_run();
    wait_sb(300);

    // pin 3 stuck low, restarted from DONE
    mode = 1;
    push(1'b0, 8'h01, 8'h10, 14'h0004, 8'h13, 4 * 19 + 1);
    pulse_run();
    wait_sb(300);

    // driven pin 1 reads 1 against expect 0: not compared
    mode = 2;
    set_vec(8'h40, 14'h0001, 14'h0001, 14'h0000, 14'h3FFF, 1'b1);
    base_addr = 8'h40;
    push(1'b1, 8'h00, 8'h00, 14'h0000, 8'h40, 20);
    pulse_run();
    wait_sb(200);

    // top of ROM without a last flag: stop and fail
    set_vec(8'hFF, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 1'b0);
    base_addr = 8'hFF;
    push(1'b0, 8'h00, 8'h00, 14'h0000, 8'hFF, 20);
    pulse_run();
    wait_sb(200);

    // 256 failing vectors saturate the counter
    for (int i = 0; i < 256; i++)
      set_vec(i, '0, '0, 14'h0002, 14'h0002, 1'b0);
    base_addr = 8'h00;
    push(1'b0, 8'hFF, 8'h00, 14'h0002, 8'hFF, 256 * 19 + 1);
    pulse_run();
    wait_sb(6000);

    // reset in the middle of SETTLE with all pins driven
    set_vec(8'h20, 14'h1555, 14'h3FFF, 14'h0000, 14'h0000, 1'b1);
    base_addr = 8'h20;
    pulse_run();
    n = 0;
    while (pin_oe !== 14'h3FFF && n < 50) begin
      @(negedge Clk);
      n++;
    end
    chk("settle_pin_oe", 32'(pin_oe), 32'h3FFF);
    chk("settle_busy", 32'(busy), 32'd1);
    @(posedge Clk); #5 Reset = 1'b0;
    #1;
    chk("midrst_pin_oe", 32'(pin_oe), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_pin_out", 32'(pin_out), 32'd0);
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    repeat (6) @(negedge Clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
